// File: rtl/ps2_key_controls.sv
// PS/2 keyboard front end: synchronises and filters the raw pins, deserialises frames,
// decodes scan-code set 2 make/break sequences and drives the game movement/fire/pause controls.
module ps2_key_controls #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIRE_PERIOD = 2500000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic       pause,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int PW = $clog2(FIRE_PERIOD + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] FIRE_LAST = PW'(FIRE_PERIOD - 1);

    typedef enum logic {F_IDLE, F_RX} fstate_t;
    typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dstate_t;

    logic          clk_meta_reg, clk_sync_reg, data_meta_reg, data_sync_reg;
    logic          clk_filt_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          fall_reg, fall_bit_reg;

    fstate_t       fstate_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic [7:0]    scancode_reg;
    logic          scancode_valid_reg, frame_err_reg;
    logic [10:0]   frame_word;
    logic          frame_ok;

    dstate_t       dstate_reg, dstate_next;
    logic          arrow_left_reg, arrow_right_reg, key_a_reg, key_d_reg, key_space_reg, key_p_reg;
    logic          arrow_left_next, arrow_right_next, key_a_next, key_d_next, key_space_next, key_p_next;
    logic          pause_reg, pause_next;
    logic          left_next, right_next;
    logic          ext, brk;
    logic [PW-1:0] fire_cnt_reg;
    logic          fire_reg, move_left_reg, move_right_reg;

    // A new ps2_clk level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
            clk_filt_reg  <= 1'b1;
            filt_cnt_reg  <= '0;
            fall_reg      <= 1'b0;
            fall_bit_reg  <= 1'b0;
        end else begin
            clk_meta_reg  <= ps2_clk;
            clk_sync_reg  <= clk_meta_reg;
            data_meta_reg <= ps2_data;
            data_sync_reg <= data_meta_reg;
            fall_reg      <= 1'b0;
            if (clk_sync_reg == clk_filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FILT_LAST) begin
                filt_cnt_reg <= '0;
                clk_filt_reg <= clk_sync_reg;
                fall_reg     <= clk_filt_reg;
                fall_bit_reg <= data_sync_reg;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign frame_word = {fall_bit_reg, shift_reg};
    assign frame_ok   = ~frame_word[0] & frame_word[10] & (^frame_word[9:1]);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            fstate_reg         <= F_IDLE;
            bit_cnt_reg        <= '0;
            shift_reg          <= '0;
            tmo_cnt_reg        <= '0;
            scancode_reg       <= 8'h00;
            scancode_valid_reg <= 1'b0;
            frame_err_reg      <= 1'b0;
        end else begin
            scancode_valid_reg <= 1'b0;
            frame_err_reg      <= 1'b0;
            case (fstate_reg)
                F_IDLE: begin
                    tmo_cnt_reg <= '0;
                    if (fall_reg) begin
                        shift_reg   <= {fall_bit_reg, shift_reg[9:1]};
                        bit_cnt_reg <= 4'd1;
                        fstate_reg  <= F_RX;
                    end
                end
                F_RX: begin
                    if (fall_reg) begin
                        tmo_cnt_reg <= '0;
                        shift_reg   <= {fall_bit_reg, shift_reg[9:1]};
                        if (bit_cnt_reg == 4'd10) begin
                            bit_cnt_reg <= '0;
                            fstate_reg  <= F_IDLE;
                            if (frame_ok) begin
                                scancode_reg       <= frame_word[8:1];
                                scancode_valid_reg <= 1'b1;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        tmo_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        fstate_reg  <= F_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                default: fstate_reg <= F_IDLE;
            endcase
        end
    end

    assign ext = (dstate_reg == D_E0) || (dstate_reg == D_E0F0);
    assign brk = (dstate_reg == D_F0) || (dstate_reg == D_E0F0);

    always_comb begin
        dstate_next      = dstate_reg;
        arrow_left_next  = arrow_left_reg;
        arrow_right_next = arrow_right_reg;
        key_a_next       = key_a_reg;
        key_d_next       = key_d_reg;
        key_space_next   = key_space_reg;
        key_p_next       = key_p_reg;
        pause_next       = pause_reg;
        if (scancode_valid_reg) begin
            dstate_next = D_IDLE;
            if (scancode_reg == 8'hE0) begin
                dstate_next = D_E0;
            end else if (scancode_reg == 8'hF0) begin
                dstate_next = ext ? D_E0F0 : D_F0;
            end else begin
                case (scancode_reg)
                    8'h6B: if (ext) arrow_left_next = ~brk;
                    8'h74: if (ext) arrow_right_next = ~brk;
                    8'h1C: key_a_next = ~brk;
                    8'h23: key_d_next = ~brk;
                    8'h29: key_space_next = ~brk;
                    8'h4D: begin
                        if (!ext) begin
                            key_p_next = ~brk;
                            // Only a fresh press toggles; typematic repeats find the bit already set.
                            if (!brk && !key_p_reg) pause_next = ~pause_reg;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign left_next  = arrow_left_next | key_a_next;
    assign right_next = arrow_right_next | key_d_next;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            dstate_reg      <= D_IDLE;
            arrow_left_reg  <= 1'b0;
            arrow_right_reg <= 1'b0;
            key_a_reg       <= 1'b0;
            key_d_reg       <= 1'b0;
            key_space_reg   <= 1'b0;
            key_p_reg       <= 1'b0;
            pause_reg       <= 1'b0;
            fire_cnt_reg    <= '0;
            fire_reg        <= 1'b0;
            move_left_reg   <= 1'b0;
            move_right_reg  <= 1'b0;
        end else begin
            dstate_reg      <= dstate_next;
            arrow_left_reg  <= arrow_left_next;
            arrow_right_reg <= arrow_right_next;
            key_a_reg       <= key_a_next;
            key_d_reg       <= key_d_next;
            key_space_reg   <= key_space_next;
            key_p_reg       <= key_p_next;
            pause_reg       <= pause_next;
            move_left_reg   <= left_next & ~right_next & ~pause_next;
            move_right_reg  <= right_next & ~left_next & ~pause_next;
            fire_reg        <= 1'b0;
            // Fresh press shoots immediately and restarts the auto-fire interval.
            if (!key_space_next || pause_next) begin
                fire_cnt_reg <= '0;
            end else if (!key_space_reg) begin
                fire_reg     <= 1'b1;
                fire_cnt_reg <= '0;
            end else if (fire_cnt_reg == FIRE_LAST) begin
                fire_reg     <= 1'b1;
                fire_cnt_reg <= '0;
            end else begin
                fire_cnt_reg <= fire_cnt_reg + 1'b1;
            end
        end
    end

    assign move_left      = move_left_reg;
    assign move_right     = move_right_reg;
    assign fire           = fire_reg;
    assign pause          = pause_reg;
    assign scancode       = scancode_reg;
    assign scancode_valid = scancode_valid_reg;
    assign frame_err      = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_controls.sv
// Directed bench for ps2_key_controls: bit-bangs PS/2 frames and checks decoded controls.
module tb_ps2_key_controls;

    localparam int FILT = 4;
    localparam int TMO  = 400;
    localparam int FP   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       move_left, move_right, fire, pause, scancode_valid, frame_err;
    logic [7:0] scancode;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fire_cnt = 0, valid_cnt = 0, err_cnt = 0;
    int fire_cyc = 0, valid_cyc = 0;

    ps2_key_controls #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO), .FIRE_PERIOD(FP)) dut (
        .iVGA_CLK(clk),
        .iRST_n(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .move_left(move_left),
        .move_right(move_right),
        .fire(fire),
        .pause(pause),
        .scancode(scancode),
        .scancode_valid(scancode_valid),
        .frame_err(frame_err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (fire === 1'b1) begin fire_cnt = fire_cnt + 1; fire_cyc = cyc; end
        if (scancode_valid === 1'b1) begin valid_cnt = valid_cnt + 1; valid_cyc = cyc; end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = w[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_parity);
        logic [10:0] w;
        w = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        send_bits(w, 11);
        wait_cyc(20);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        checks++;
        if ({move_left, move_right, fire, pause, scancode_valid, frame_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {move_left, move_right, fire, pause, scancode_valid, frame_err});
        end
        checks++;
        if (scancode !== 8'h00) begin
            failures++;
            $display("FAIL reset_scancode: got %0h expected 00", scancode);
        end
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_single_fire;
        int f0, v0;
        f0 = fire_cnt; v0 = valid_cnt;
        send_byte(8'h29, 1'b0);
        chk("space_scancode", int'(scancode), 'h29);
        chk("space_valid_pulses", valid_cnt - v0, 1);
        chk("space_fire_pulses", fire_cnt - f0, 1);
        chk("fire_latency", fire_cyc - valid_cyc, 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h29, 1'b0);
        chk("space_break_no_fire", fire_cnt - f0, 1);
    endtask

    task automatic test_arrow;
        int e0;
        e0 = err_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h6B, 1'b0);
        chk("arrow_left_make", int'(move_left), 1);
        chk("arrow_left_right0", int'(move_right), 0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h6B, 1'b0);
        chk("arrow_left_break", int'(move_left), 0);
        chk("arrow_no_err", err_cnt - e0, 0);
    endtask

    task automatic test_both_keys;
        send_byte(8'h1C, 1'b0);
        chk("a_left", int'(move_left), 1);
        send_byte(8'h23, 1'b0);
        chk("ad_left", int'(move_left), 0);
        chk("ad_right", int'(move_right), 0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("d_right", int'(move_right), 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h23, 1'b0);
        chk("d_release", int'(move_right), 0);
    endtask

    task automatic test_pause;
        send_byte(8'h1C, 1'b0);
        send_byte(8'h4D, 1'b0);
        chk("pause_on", int'(pause), 1);
        chk("pause_blocks_left", int'(move_left), 0);
        send_byte(8'h4D, 1'b0);
        chk("pause_repeat", int'(pause), 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h4D, 1'b0);
        chk("pause_break", int'(pause), 1);
        send_byte(8'h4D, 1'b0);
        chk("pause_off", int'(pause), 0);
        chk("left_resumes", int'(move_left), 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("left_release", int'(move_left), 0);
    endtask

    task automatic test_errors;
        int e0, f0, v0;
        logic [7:0] prev;
        e0 = err_cnt; f0 = fire_cnt; v0 = valid_cnt; prev = scancode;
        send_byte(8'h29, 1'b1);
        chk("bad_parity_err", err_cnt - e0, 1);
        chk("bad_parity_no_fire", fire_cnt - f0, 0);
        chk("bad_parity_no_valid", valid_cnt - v0, 0);
        chk("bad_parity_scancode", int'(scancode), int'(prev));
        send_bits(11'h7FE, 5);
        wait_cyc(600);
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0);
        chk("after_abort_valid", valid_cnt - v0, 1);
        chk("after_abort_err", err_cnt - e0, 0);
        chk("after_abort_left", int'(move_left), 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
    endtask

    task automatic test_autofire;
        int f0;
        f0 = fire_cnt;
        send_byte(8'h29, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(300);
            send_byte(8'h29, 1'b0);
        end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h29, 1'b0);
        wait_cyc(3 * FP);
        chk("autofire_pulses", fire_cnt - f0, 4);
    endtask

    task automatic test_mid_reset;
        send_byte(8'h1C, 1'b0);
        send_bits(11'h7FE, 3);
        rst_n = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        chk("midreset_left", int'(move_left), 0);
        chk("midreset_scancode", int'(scancode), 0);
        rst_n = 1'b1;
        wait_cyc(5);
        send_byte(8'h23, 1'b0);
        chk("midreset_next_code", int'(scancode), 'h23);
        chk("midreset_right", int'(move_right), 1);
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_arrow();
        test_both_keys();
        test_pause();
        test_errors();
        test_autofire();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
